// File: rtl/fsk_rx_sequencer.sv
// fsk_rx_sequencer: classifies FSK symbols, locks on preamble/delimiter and assembles data words.
module fsk_rx_sequencer #(
  parameter int NBITS = 12,
  parameter int PREAMBLE_MIN = 5,
  parameter int TIMEOUT = 2000000
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic [31:0]      freq_in,
  input  logic             freq_valid,
  input  logic [31:0]      thr_bit,
  input  logic [31:0]      f_min,
  output logic [1:0]       state,
  output logic             locked,
  output logic             bit_out,
  output logic             bit_valid,
  output logic [NBITS-1:0] data_word,
  output logic             word_valid,
  output logic             loss
);
  localparam int ZW = $clog2(PREAMBLE_MIN + 1);
  localparam int BW = $clog2(NBITS);
  localparam int TW = $clog2(TIMEOUT);
  localparam logic [ZW-1:0] ZMAX = ZW'(PREAMBLE_MIN);
  localparam logic [BW-1:0] BMAX = BW'(NBITS - 1);
  localparam logic [TW-1:0] TMAX = TW'(TIMEOUT - 1);
  typedef enum logic [1:0] {IDLE, HUNT, SYNC, DATA} state_t;
  state_t cur, nxt;
  logic [ZW-1:0] zcnt, zcnt_n;
  logic [BW-1:0] bcnt, bcnt_n;
  logic [TW-1:0] tcnt, tcnt_n;
  logic [NBITS-1:0] shreg, shreg_n, word_n, shifted;
  logic bit_n, bv_n, wv_n, loss_n, sym_one, lost;
  assign sym_one = freq_in >= thr_bit;
  assign lost = (freq_valid && freq_in < f_min) || (!freq_valid && tcnt == TMAX);
  assign shifted = {shreg[NBITS-2:0], sym_one};
  assign state = cur;
  always_comb begin
    nxt = cur;
    zcnt_n = zcnt;
    bcnt_n = bcnt;
    tcnt_n = tcnt == TMAX ? tcnt : tcnt + TW'(1);
    shreg_n = shreg;
    word_n = data_word;
    bit_n = bit_out;
    bv_n = 1'b0;
    wv_n = 1'b0;
    loss_n = 1'b0;
    if (!en) begin
      nxt = IDLE;
      zcnt_n = '0;
      bcnt_n = '0;
      tcnt_n = '0;
      shreg_n = '0;
      word_n = '0;
    end else if (cur == IDLE) begin
      nxt = HUNT;
      tcnt_n = '0;
    end else if (lost) begin
      nxt = HUNT;
      loss_n = 1'b1;
      zcnt_n = '0;
      bcnt_n = '0;
      tcnt_n = '0;
      shreg_n = '0;
    end else if (freq_valid) begin
      tcnt_n = '0;
      case (cur)
        HUNT: begin
          zcnt_n = sym_one ? '0 : (zcnt == ZMAX ? zcnt : zcnt + ZW'(1));
          nxt = (!sym_one && zcnt_n == ZMAX) ? SYNC : HUNT;
        end
        SYNC: begin
          nxt = sym_one ? DATA : SYNC;
          bcnt_n = '0;
          shreg_n = '0;
        end
        DATA: begin
          bit_n = sym_one;
          bv_n = 1'b1;
          shreg_n = shifted;
          wv_n = bcnt == BMAX;
          word_n = wv_n ? shifted : data_word;
          bcnt_n = wv_n ? '0 : bcnt + BW'(1);
        end
        default: ;
      endcase
    end
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cur <= IDLE;
      zcnt <= '0;
      bcnt <= '0;
      tcnt <= '0;
      shreg <= '0;
      data_word <= '0;
      locked <= 1'b0;
      bit_out <= 1'b0;
      bit_valid <= 1'b0;
      word_valid <= 1'b0;
      loss <= 1'b0;
    end else begin
      cur <= nxt;
      zcnt <= zcnt_n;
      bcnt <= bcnt_n;
      tcnt <= tcnt_n;
      shreg <= shreg_n;
      data_word <= word_n;
      locked <= nxt == DATA;
      bit_out <= bit_n;
      bit_valid <= bv_n;
      word_valid <= wv_n;
      loss <= loss_n;
    end
  end
endmodule
